demux1x2_stream: RTL

DEMUX1X2_STREAM -- requirements
Module: demux1x2_stream

---
 rtl/demux1x2_stream.sv | 133 +++++++++++++
 1 files changed

// File: rtl/demux1x2_stream.sv
// rtl/demux1x2_stream.sv - one-input, two-output stream demultiplexer with per-channel holding registers
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   in_data [WIDTH]          upstream word
//   in_sel                   destination channel, 0 -> out0, 1 -> out1
//   out0_valid / out0_ready  channel 0 handshake
//   out0_data [WIDTH]        channel 0 held word
//   out0_count [16]          channel 0 delivered-word count (wraps)
//   out1_*                   same set for channel 1

module demux1x2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [15:0]      out0_count,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [15:0]      out1_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state0;
  state_t           r_state1;
  state_t           w_next0;
  state_t           w_next1;
  logic [WIDTH-1:0] r_data0;
  logic [WIDTH-1:0] r_data1;
  logic [15:0]      r_count0;
  logic [15:0]      r_count1;

  logic w_ch0_open;
  logic w_ch1_open;
  logic w_in_xfer;
  logic w_load0;
  logic w_load1;
  logic w_out_xfer0;
  logic w_out_xfer1;

  // A channel can take a word when empty, or when its current word leaves
  // in the same cycle. Only the addressed channel gates in_ready, so a
  // stalled channel never blocks the other one.
  assign w_ch0_open = (r_state0 == ST_EMPTY) || out0_ready;
  assign w_ch1_open = (r_state1 == ST_EMPTY) || out1_ready;

  // rst_n is folded in so nothing is accepted while reset is held.
  assign in_ready = rst_n && (in_sel ? w_ch1_open : w_ch0_open);

  assign w_in_xfer   = in_valid && in_ready;
  assign w_load0     = w_in_xfer && !in_sel;
  assign w_load1     = w_in_xfer &&  in_sel;
  assign w_out_xfer0 = (r_state0 == ST_FULL) && out0_ready;
  assign w_out_xfer1 = (r_state1 == ST_FULL) && out1_ready;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state0 <= ST_EMPTY;
      r_state1 <= ST_EMPTY;
    end else begin
      r_state0 <= w_next0;
      r_state1 <= w_next1;
    end
  end

  // Next-state logic; a load while FULL is the reload case (stay FULL)
  always_comb begin
    w_next0 = r_state0;
    case (r_state0)
      ST_EMPTY: if (w_load0) w_next0 = ST_FULL;
      ST_FULL:  if (!w_load0 && w_out_xfer0) w_next0 = ST_EMPTY;
      default:  w_next0 = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_next1 = r_state1;
    case (r_state1)
      ST_EMPTY: if (w_load1) w_next1 = ST_FULL;
      ST_FULL:  if (!w_load1 && w_out_xfer1) w_next1 = ST_EMPTY;
      default:  w_next1 = ST_EMPTY;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    out0_valid = (r_state0 == ST_FULL);
    out1_valid = (r_state1 == ST_FULL);
  end

  // Holding registers change only on a load to their own channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      if (w_load0) r_data0 <= in_data;
      if (w_load1) r_data1 <= in_data;
    end
  end

  // Delivered-word counters, wrap naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count0 <= '0;
      r_count1 <= '0;
    end else begin
      if (w_out_xfer0) r_count0 <= r_count0 + 16'd1;
      if (w_out_xfer1) r_count1 <= r_count1 + 16'd1;
    end
  end

  assign out0_data  = r_data0;
  assign out1_data  = r_data1;
  assign out0_count = r_count0;
  assign out1_count = r_count1;

endmodule
